// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch controller: synchronized START/LAP/CLR buttons drive an IDLE/RUN/PAUSE/LAP
// FSM; a TICK_DIV prescaler advances a 4-digit BCD count shown on registered digit outputs.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_START,
  input  logic       BTN_LAP,
  input  logic       BTN_CLR,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int unsigned   PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  logic [2:0]    w_btn, w_pulse;
  logic [2:0]    r_sync1, r_sync2, r_hist;
  logic          w_start, w_lap, w_clr;
  logic [1:0]    r_state, w_next;
  logic [PW-1:0] r_presc;
  logic          w_cnt_en, w_tick, w_carry;
  logic [15:0]   r_cnt, r_lap, r_disp, w_cnt_inc;
  logic          r_ovf;

  assign w_btn = {BTN_CLR, BTN_LAP, BTN_START};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_pulse = r_sync2 & ~r_hist;
  assign w_start = w_pulse[0];
  assign w_lap   = w_pulse[1];
  assign w_clr   = w_pulse[2];

  // Only pulses meaningful in the current state are considered, so priority
  // falls through to the next valid one (e.g. START beats an ignored CLR in RUN).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN:   if (w_start) w_next = S_PAUSE;
               else if (w_lap) w_next = S_LAP;
      S_LAP:   if (w_start) w_next = S_PAUSE;
               else if (w_lap) w_next = S_RUN;
      S_PAUSE: if (w_clr) w_next = S_IDLE;
               else if (w_start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Prescaler is gated by the state being entered, so the edge that pauses holds its value.
  assign w_cnt_en = (w_next == S_RUN) || (w_next == S_LAP);
  assign w_tick   = w_cnt_en && (r_presc == P_MAX);

  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_cnt[4*i +: 4] == 4'd9) begin
          w_cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_cnt   <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_state <= w_next;
      r_disp  <= (r_state == S_LAP) ? r_lap : r_cnt;
      if (w_next == S_IDLE) begin
        r_presc <= '0;
        r_cnt   <= '0;
        r_lap   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_cnt_en)
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_cnt <= w_cnt_inc;
          if (w_carry)
            r_ovf <= 1'b1;
        end
        if ((r_state == S_RUN) && (w_next == S_LAP))
          r_lap <= r_cnt;
      end
    end
  end

  assign {d0, d1, d2, d3} = r_disp;
  assign running          = (r_state == S_RUN) || (r_state == S_LAP);
  assign lap_active       = (r_state == S_LAP);
  assign ovf              = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expected values are worked out
// edge-by-edge from button timing (action on the 3rd edge after a level rises).
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] btn;
  logic       BTN_START, BTN_LAP, BTN_CLR;
  logic [3:0] d0, d1, d2, d3;
  logic       running, lap_active, ovf;
  logic [15:0] disp;

  int n_checks = 0;
  int n_errors = 0;

  assign BTN_START = btn[0];
  assign BTN_LAP   = btn[1];
  assign BTN_CLR   = btn[2];
  assign disp      = {d0, d1, d2, d3};

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_START  (BTN_START),
    .BTN_LAP    (BTN_LAP),
    .BTN_CLR    (BTN_CLR),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  // Raise the masked buttons at this negedge; they act on the 3rd posedge and are
  // released at the negedge right after it.
  task automatic press(input logic [2:0] m);
    btn = btn | m;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    btn = btn & ~m;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b1;
    btn   = 3'b000;
    #2 RST_N = 1'b0;
    #1;
    check("rst_disp", disp, 16'h0000);
    check("rst_flags", {running, lap_active, ovf}, 3'b000);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Held START from IDLE, then free-run to the 99.99 -> 00.00 wrap
    step(1);
    btn[0] = 1'b1;
    step(2);
    check("start_edge2", running, 1'b0);
    step(1);
    check("start_edge3", running, 1'b1);
    step(3);
    check("tick1_lag", disp, 16'h0000);
    step(1);
    check("tick1_disp", disp, 16'h0001);
    step(33);
    check("nine_ticks", disp, 16'h0009);
    check("held_one_pulse", {running, lap_active, ovf}, 3'b100);
    btn[0] = 1'b0;
    step(39959);
    check("at_9999", disp, 16'h9999);
    check("no_ovf_yet", ovf, 1'b0);
    step(3);
    check("ovf_set", ovf, 1'b1);
    check("wrap_lag", disp, 16'h9999);
    step(1);
    check("wrap_disp", disp, 16'h0000);
    press(3'b100);
    step(1);
    check("clr_in_run_disp", disp, 16'h0001);
    check("clr_in_run_flags", {running, ovf}, 2'b11);

    // Lap freeze at 00.05 while the live count runs on
    do_reset();
    press(3'b001);
    step(17);
    press(3'b010);
    check("lap_enter", lap_active, 1'b1);
    step(11);
    check("lap_frozen", disp, 16'h0005);
    check("lap_flags", {running, lap_active}, 2'b11);
    press(3'b010);
    check("lap_release_state", {running, lap_active}, 2'b10);
    check("lap_release_lag", disp, 16'h0005);
    step(1);
    check("lap_release_disp", disp, 16'h0008);

    // Pause holds the prescaler; CLR from PAUSE zeroes everything
    do_reset();
    press(3'b001);
    step(3);
    press(3'b001);
    check("pause_state", running, 1'b0);
    step(1);
    press(3'b001);
    check("resume_state", running, 1'b1);
    step(1);
    check("resume_lag", disp, 16'h0001);
    step(1);
    check("resume_tick", disp, 16'h0002);
    press(3'b001);
    step(1);
    press(3'b100);
    check("clr_idle", {running, lap_active}, 2'b00);
    step(1);
    check("clr_disp", disp, 16'h0000);
    check("clr_ovf", ovf, 1'b0);
    step(1);
    press(3'b001);
    step(3);
    check("presc_zero_lag", disp, 16'h0000);
    step(1);
    check("presc_zero_tick", disp, 16'h0001);

    // Same-cycle priority
    do_reset();
    press(3'b001);
    step(1);
    press(3'b001);
    step(1);
    press(3'b101);
    check("clr_beats_start", running, 1'b0);
    step(1);
    check("clr_beats_start_disp", disp, 16'h0000);
    press(3'b001);
    check("restart", running, 1'b1);
    step(1);
    press(3'b011);
    check("start_beats_lap", {running, lap_active}, 2'b00);

    // Reset mid-LAP with LAP held through release
    do_reset();
    press(3'b001);
    step(5);
    press(3'b010);
    check("lap2_enter", lap_active, 1'b1);
    step(4);
    check("lap2_disp", disp, 16'h0002);
    btn[1] = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_disp", disp, 16'h0000);
    check("async_rst_flags", {running, lap_active, ovf}, 3'b000);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    step(3);
    check("held_lap_ignored", {running, lap_active}, 2'b00);
    press(3'b001);
    step(6);
    check("no_residual_lap", {running, lap_active}, 2'b10);
    btn = 3'b000;

    // START held through reset release gives exactly one pulse
    @(negedge CLK);
    RST_N = 1'b0;
    btn = 3'b001;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    step(2);
    check("held_start_edge2", running, 1'b0);
    step(1);
    check("held_start_edge3", running, 1'b1);
    step(8);
    check("held_start_single", running, 1'b1);
    btn = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1_000_000, CLK cycles per 10 ms hundredths tick (100 MHz CLK).
REQ-002 CLK  input  1  system clock, 100 MHz; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK.
REQ-004 BTN_START  input  1  start/stop button level, asynchronous to CLK.
REQ-005 BTN_LAP  input  1  lap button level, asynchronous to CLK.
REQ-006 BTN_CLR  input  1  clear button level, asynchronous to CLK.
REQ-007 d0  output  4  BCD tens of seconds (leftmost digit).
REQ-008 d1  output  4  BCD units of seconds.
REQ-009 d2  output  4  BCD tenths.
REQ-010 d3  output  4  BCD hundredths (rightmost digit).
REQ-011 running  output  1  high in RUN or LAP.
REQ-012 lap_active  output  1  high in LAP.
REQ-013 ovf  output  1  sticky wrap flag.

Function
REQ-014 Each BTN_* input SHALL pass through a 2-flop synchronizer and a third history flop; the pulse is synchronized-high AND history-low, one cycle wide.
REQ-015 A pulse SHALL act on the 3rd rising CLK edge after the button level rises; holding a button SHALL produce exactly one pulse.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE, LAP.
REQ-017 Same-cycle pulses SHALL be prioritized CLR > START > LAP; only the highest-priority pulse valid in the current state acts, and the others are discarded.
REQ-018 IDLE: START -> RUN; LAP and CLR are ignored.
REQ-019 RUN: START -> PAUSE; LAP -> LAP, capturing the live count into the lap register on the same edge; CLR is ignored.
REQ-020 LAP: START -> PAUSE with the display released to the live count; LAP -> RUN with the display released; CLR is ignored.
REQ-021 PAUSE: START -> RUN; CLR -> IDLE; LAP is ignored.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and LAP, SHALL hold in PAUSE, and SHALL be zeroed on entry to IDLE; a tick fires on the cycle the prescaler equals TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
REQ-023 On each tick the live count SHALL increment as 4-digit BCD with per-digit carry at 9.
REQ-024 On a tick at 99.99 the live count SHALL wrap to 00.00 and ovf SHALL set; ovf stays set until entry to IDLE.
REQ-025 Outputs d0..d3 SHALL be registered; in LAP they show the lap register, otherwise the live count, both updating the cycle after the source changes.
REQ-026 The live count SHALL keep incrementing in LAP.
REQ-027 Entry to IDLE SHALL zero the live count, the lap register, the prescaler and ovf.
REQ-028 running and lap_active SHALL be decoded from the registered state with no extra latency.

Reset
REQ-029 While RST_N is low, the state SHALL be IDLE and all of the following SHALL be 0: synchronizer/history flops, prescaler, live count, lap register, d0..d3, running, lap_active, ovf.
REQ-030 Reset asserted mid-RUN or mid-LAP SHALL abort immediately with no residual pulse after release.
REQ-031 A button already held high through reset release SHALL produce one pulse after release.

Verification (TICK_DIV=4)
REQ-032 Scenario: reset; BTN_START high; 40 cycles -> running=1 by edge 3; 9 ticks; d=0,0,0,9.
REQ-033 Scenario: start from 99.98 (forced); 2 ticks -> d=0,0,0,0; ovf=1; BTN_CLR while RUN -> no change.
REQ-034 Scenario: RUN at 00.05; LAP pulse; 3 ticks -> d stays 0,0,0,5; lap_active=1; LAP pulse -> d=0,0,0,8 the next cycle.
REQ-035 Scenario: RUN; START at prescaler=2 -> PAUSE, prescaler holds 2; START -> next tick after 1 more cycle; PAUSE then CLR -> IDLE, all digits 0, ovf=0.
REQ-036 Scenario: PAUSE; START and CLR pulses in the same cycle -> IDLE (CLR wins); RUN; START and LAP in the same cycle -> PAUSE.
REQ-037 Scenario: RST_N low mid-LAP -> all outputs 0 asynchronously; held BTN_LAP across release -> single pulse, ignored in IDLE.
